// File: rtl/counter_fractional_multi.sv
// Multi-channel fractional-rate (Bresenham) counter with handshaked reconfiguration applied at wrap boundaries.
// Optional phase-load ports are enabled by defining COUNTER_FRACTIONAL_MULTI_PHASE_EN.
module counter_fractional_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             ena,
  input  logic [CHANNELS-1:0]             cfg_vld,
  output logic [CHANNELS-1:0]             cfg_rdy,
  input  logic [CHANNELS-1:0][WIDTH-1:0]  cfg_num,
  input  logic [CHANNELS-1:0][WIDTH-1:0]  cfg_den,
  output logic [CHANNELS-1:0][WIDTH-1:0]  cnt,
  output logic [CHANNELS-1:0]             wrp,
  output logic [CHANNELS-1:0]             err
`ifdef COUNTER_FRACTIONAL_MULTI_PHASE_EN
  ,
  input  logic [CHANNELS-1:0]             phs_ld,
  input  logic [CHANNELS-1:0][WIDTH-1:0]  phs_val
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};

  // A stored denominator of zero stands for 2**WIDTH.
  function automatic logic [WIDTH:0] eff_den(input logic [WIDTH-1:0] d);
    return (d == '0) ? FULL : {1'b0, d};
  endfunction

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, num, den, sh_num, sh_den, acc_nxt, stepped;
    logic [WIDTH:0]   sum, d_cur, d_sh;
    logic             wrap, take, legal, apply, err_q;

    always_comb begin
      sum     = {1'b0, acc} + {1'b0, num};
      d_cur   = eff_den(den);
      d_sh    = eff_den(sh_den);
      wrap    = (sum >= d_cur);
      // Result is below D <= 2**WIDTH, so the low bits alone are exact.
      stepped = wrap ? (sum[WIDTH-1:0] - d_cur[WIDTH-1:0]) : sum[WIDTH-1:0];
      take    = (state == IDLE) && cfg_vld[ch];
      legal   = ({1'b0, cfg_num[ch]} < eff_den(cfg_den[ch]));
      apply   = (state == PEND) && (!ena[ch] || wrap);

      state_nxt = state;
      if (apply)              state_nxt = IDLE;
      else if (take && legal) state_nxt = PEND;

      acc_nxt = acc;
      if (ena[ch])                             acc_nxt = stepped;
      else if (apply && ({1'b0, acc} >= d_sh)) acc_nxt = '0;
`ifdef COUNTER_FRACTIONAL_MULTI_PHASE_EN
      if (phs_ld[ch])
        acc_nxt = ({1'b0, phs_val[ch]} >= (apply ? d_sh : d_cur)) ? '0 : phs_val[ch];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state  <= IDLE;
        acc    <= '0;
        num    <= '0;
        den    <= '0;
        sh_num <= '0;
        sh_den <= '0;
        err_q  <= 1'b0;
      end else begin
        state <= state_nxt;
        acc   <= acc_nxt;
        if (take && legal) begin
          sh_num <= cfg_num[ch];
          sh_den <= cfg_den[ch];
        end
        if (take && !legal) err_q <= 1'b1;
        if (apply) begin
          num <= sh_num;
          den <= sh_den;
        end
      end
    end

    assign cnt[ch]     = acc;
    assign wrp[ch]     = wrap;
    assign cfg_rdy[ch] = (state == IDLE);
    assign err[ch]     = err_q;
  end

endmodule

// File: tb/tb_counter_fractional_multi.sv
// Self-checking bench for counter_fractional_multi: directed scenarios plus random traffic
// checked every cycle against an integer reference model.
module tb_counter_fractional_multi;
  localparam int W  = 8;
  localparam int CH = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [CH-1:0]          ena, cfg_vld, cfg_rdy, wrp, err;
  logic [CH-1:0][W-1:0]   cfg_num, cfg_den, cnt;
`ifdef COUNTER_FRACTIONAL_MULTI_PHASE_EN
  logic [CH-1:0]          phs_ld = '0;
  logic [CH-1:0][W-1:0]   phs_val = '0;
`endif

  counter_fractional_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .cfg_num(cfg_num), .cfg_den(cfg_den), .cnt(cnt), .wrp(wrp), .err(err)
`ifdef COUNTER_FRACTIONAL_MULTI_PHASE_EN
    , .phs_ld(phs_ld), .phs_val(phs_val)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: integer accumulator, active rate, pending shadow config.
  int m_acc[CH], m_num[CH], m_D[CH], m_pend[CH], m_snum[CH], m_sD[CH], m_err[CH], m_taken[CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0; m_num[c] = 0; m_D[c] = 256; m_pend[c] = 0;
      m_snum[c] = 0; m_sD[c] = 256; m_err[c] = 0; m_taken[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      int s, w, ap, na, dn;
      s  = m_acc[c] + m_num[c];
      w  = (s >= m_D[c]) ? 1 : 0;
      ap = (m_pend[c] != 0 && (!ena[c] || w != 0)) ? 1 : 0;
      if (ena[c])      na = (w != 0) ? s - m_D[c] : s;
      else if (ap != 0) na = (m_acc[c] < m_sD[c]) ? m_acc[c] : 0;
      else             na = m_acc[c];
      if (m_pend[c] == 0 && cfg_vld[c]) begin
        dn = (cfg_den[c] == 0) ? 256 : int'(cfg_den[c]);
        if (int'(cfg_num[c]) < dn) begin
          m_pend[c] = 1; m_snum[c] = int'(cfg_num[c]); m_sD[c] = dn; m_taken[c]++;
        end else m_err[c] = 1;
      end
      if (ap != 0) begin
        m_num[c] = m_snum[c]; m_D[c] = m_sD[c]; m_pend[c] = 0;
      end
      m_acc[c] = na;
    end
  endtask

  task automatic check_all(input string where);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s_cnt%0d", where, c), 32'(cnt[c]), 32'(m_acc[c]));
      chk($sformatf("%s_wrp%0d", where, c), 32'(wrp[c]), (m_acc[c] + m_num[c] >= m_D[c]) ? 32'd1 : 32'd0);
      chk($sformatf("%s_rdy%0d", where, c), 32'(cfg_rdy[c]), (m_pend[c] == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_err%0d", where, c), 32'(err[c]), 32'(m_err[c]));
    end
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  initial begin
    int seq[20];
    int exp_seq[11] = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7, 0};
    int wraps, t0, done;

    rst = 1'b0; ena = '0; cfg_vld = '0; cfg_num = '0; cfg_den = '0;
    model_reset();
    #12;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_wrp", 32'(wrp), 32'd0);
    chk("rst_rdy", 32'(cfg_rdy), 32'd3);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk) rst = 1'b1;
    step("idle");

    // num=3 den=10 on channel 0, applied through an ena=0 edge
    cfg_vld[0] = 1'b1; cfg_num[0] = 8'd3; cfg_den[0] = 8'd10;
    step("cfg1_take");
    cfg_vld[0] = 1'b0;
    step("cfg1_apply");
    ena[0] = 1'b1;
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      seq[i] = int'(cnt[0]);
      if (wrp[0]) wraps++;
      step("run3_10");
    end
    for (int i = 0; i < 11; i++) chk($sformatf("seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    chk("wraps3_10", 32'(wraps), 32'd6);

    // num=255 den=0 (2**8) on channel 1
    ena = '0;
    cfg_vld[1] = 1'b1; cfg_num[1] = 8'd255; cfg_den[1] = 8'd0;
    step("cfg255_take");
    cfg_vld[1] = 1'b0;
    step("cfg255_apply");
    ena[1] = 1'b1;
    wraps = 0;
    for (int i = 0; i < 256; i++) begin
      if (wrp[1]) wraps++;
      step("run255");
    end
    chk("wraps255", 32'(wraps), 32'd255);
    chk("cnt255_end", 32'(cnt[1]), 32'd0);
    ena[1] = 1'b0;

    // reconfigure mid-count; second request held until ready returns
    ena[0] = 1'b1;
    step("pre_recfg");
    step("pre_recfg");
    cfg_vld[0] = 1'b1; cfg_num[0] = 8'd1; cfg_den[0] = 8'd4;
    step("recfg1_take");
    chk("recfg1_busy", 32'(cfg_rdy[0]), 32'd0);
    cfg_num[0] = 8'd2; cfg_den[0] = 8'd7;
    t0 = m_taken[0]; done = 0;
    for (int i = 0; i < 30 && done == 0; i++) begin
      step("recfg2_hold");
      if (m_taken[0] != t0) done = 1;
    end
    chk("recfg2_accepted", 32'(done), 32'd1);
    cfg_vld[0] = 1'b0;
    done = 0;
    for (int i = 0; i < 30 && done == 0; i++) begin
      step("recfg2_run");
      if (m_pend[0] == 0) done = 1;
    end
    chk("recfg2_applied", 32'(done), 32'd1);
    for (int i = 0; i < 10; i++) step("rate2_7");

    // illegal configuration: consumed, discarded, sticky err
    cfg_vld[0] = 1'b1; cfg_num[0] = 8'd12; cfg_den[0] = 8'd10;
    step("illegal");
    cfg_vld[0] = 1'b0;
    chk("illegal_err", 32'(err[0]), 32'd1);
    chk("illegal_rdy", 32'(cfg_rdy[0]), 32'd1);
    for (int i = 0; i < 8; i++) step("after_illegal");

    // random enables and configurations on both channels
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        ena[c]     = ($urandom_range(0, 3) != 0);
        cfg_vld[c] = ($urandom_range(0, 9) == 0);
        cfg_den[c] = 8'($urandom_range(0, 24));
        cfg_num[c] = 8'($urandom_range(0, 26));
      end
      step("rand");
    end

    // asynchronous reset while a config is pending
    ena = '0; cfg_vld = '0;
    step("pre_rst");
    cfg_vld[0] = 1'b1; cfg_num[0] = 8'd5; cfg_den[0] = 8'd9;
    ena[0] = 1'b1;
    cfg_vld[1] = 1'b1; cfg_num[1] = 8'd200; cfg_den[1] = 8'd100;
    step("pend_before_rst");
    cfg_vld = '0;
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_cnt", 32'(cnt), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_rdy", 32'(cfg_rdy), 32'd3);
    check_all("arst");
    @(negedge clk) rst = 1'b1;
    ena = '1;
    for (int i = 0; i < 6; i++) step("post_rst");
    chk("post_rst_cnt", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
